sample_frame_sequencer: RTL and testbench

Frame-level controller for the ADC → processing → DAC sample path. It generates SPI_SCK from CLK_50M, owns the shared SPI bus, and issues the chip selects and conversion strobe in a fixed per-sample order: optional preamp gain write, ADC conversion and readout, DAC A update, DAC B update. It also drives the SPI_MOSI mux select and a one-cycle sample strobe that clocks the downstream delay/differentiator registers.

---
 rtl/sample_frame_sequencer.sv | 155 +++++++++++++++
 tb/tb_sample_frame_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_frame_sequencer.sv
// Per-sample SPI frame controller for the ADC -> processing -> DAC path.
// Generates SPI_SCK and sequences preamp gain write, ADC conversion/readout, DAC A and DAC B.
module sample_frame_sequencer #(
  parameter int unsigned FRAME_SCK = 128,
  parameter int unsigned DIV_FAST  = 4,
  parameter int unsigned DIV_SLOW  = 10
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       enable,
  input  logic       rate_sel,
  input  logic       gain_req,
  output logic       SPI_SCK,
  output logic       AMP_CS,
  output logic       AD_CONV,
  output logic       DAC_CS,
  output logic       adc_window,
  output logic       dac_sel,
  output logic [1:0] mosi_sel,
  output logic       sample_valid,
  output logic       busy
);

  if (FRAME_SCK < 108) begin : g_frame_check
    $error("FRAME_SCK must be at least 108");
  end

  localparam int unsigned    PosW    = $clog2(FRAME_SCK);
  localparam logic [PosW-1:0] PosLast = PosW'(FRAME_SCK - 1);
  localparam logic [15:0]    DivFast = 16'(DIV_FAST);
  localparam logic [15:0]    DivSlow = 16'(DIV_SLOW);

  typedef enum logic [2:0] {
    StIdle,
    StAmp,
    StConv,
    StRead,
    StDacA,
    StGap,
    StDacB
  } state_e;

  logic [15:0]     div_q, div_cnt_q;
  logic            half_done, tick_q;
  state_e          state_q, state_d;
  logic [PosW-1:0] pos_q, pos_d;
  logic [5:0]      ph_q, ph_d;
  logic            gain_q, gain_d;
  logic            busy_d, start, sample_valid_d;

  // SCK generator; the registered falling-edge tick lets outputs settle a cycle after SCK falls
  assign half_done = (div_cnt_q == div_q - 16'd1);

  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      SPI_SCK   <= 1'b0;
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= half_done && SPI_SCK;
      if (half_done) begin
        div_cnt_q <= '0;
        SPI_SCK   <= ~SPI_SCK;
      end else begin
        div_cnt_q <= div_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    ph_d           = ph_q;
    busy_d         = busy;
    gain_d         = gain_q | gain_req;
    start          = 1'b0;
    sample_valid_d = tick_q && busy && (state_q == StRead) && (ph_q == 6'd0);
    if (tick_q) begin
      if (!busy || pos_q == PosLast) begin
        // Frame boundary: either start the next frame or park at pos 0
        pos_d   = '0;
        state_d = StIdle;
        busy_d  = 1'b0;
        start   = enable;
      end else begin
        pos_d = pos_q + PosW'(1);
        if (ph_q != 6'd0 && state_q != StIdle) begin
          ph_d = ph_q - 6'd1;
        end else begin
          case (state_q)
            StAmp:   begin state_d = StConv; ph_d = 6'd0;  end
            StConv:  begin state_d = StRead; ph_d = 6'd33; end
            StRead:  begin state_d = StDacA; ph_d = 6'd31; end
            StDacA:  begin state_d = StGap;  ph_d = 6'd0;  end
            StGap:   begin state_d = StDacB; ph_d = 6'd31; end
            StDacB:  begin state_d = StIdle; ph_d = 6'd0;  end
            default: ;
          endcase
        end
      end
      if (start) begin
        busy_d = 1'b1;
        if (gain_q) begin
          state_d = StAmp;
          ph_d    = 6'd7;
          gain_d  = gain_req;  // a request coinciding with AMP entry is kept for the next frame
        end else begin
          state_d = StConv;
          ph_d    = 6'd0;
        end
      end
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      pos_q        <= '0;
      ph_q         <= '0;
      gain_q       <= 1'b1;
      div_q        <= DivFast;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      AMP_CS       <= 1'b1;
      AD_CONV      <= 1'b0;
      DAC_CS       <= 1'b1;
      adc_window   <= 1'b0;
      dac_sel      <= 1'b0;
      mosi_sel     <= 2'd0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      ph_q         <= ph_d;
      gain_q       <= gain_d;
      busy         <= busy_d;
      sample_valid <= sample_valid_d;
      if (tick_q && pos_d == '0) begin
        div_q <= rate_sel ? DivSlow : DivFast;
      end
      AMP_CS     <= (state_d != StAmp);
      AD_CONV    <= (state_d == StConv);
      adc_window <= (state_d == StRead);
      DAC_CS     <= !((state_d == StDacA) || (state_d == StDacB));
      dac_sel    <= (state_d == StDacB);
      if (state_d == StAmp) begin
        mosi_sel <= 2'd1;
      end else if (state_d == StDacA || state_d == StDacB) begin
        mosi_sel <= 2'd2;
      end else begin
        mosi_sel <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_sample_frame_sequencer.sv
// Scoreboard bench for sample_frame_sequencer: expected output events keyed by SCK fall index.
module tb_sample_frame_sequencer;

  logic       CLK_50M = 1'b0;
  logic       RST_N = 1'b0;
  logic       enable = 1'b0;
  logic       rate_sel = 1'b0;
  logic       gain_req = 1'b0;
  logic       SPI_SCK, AMP_CS, AD_CONV, DAC_CS, adc_window, dac_sel, sample_valid, busy;
  logic [1:0] mosi_sel;

  sample_frame_sequencer #(
    .FRAME_SCK(128),
    .DIV_FAST (4),
    .DIV_SLOW (10)
  ) dut (
    .CLK_50M     (CLK_50M),
    .RST_N       (RST_N),
    .enable      (enable),
    .rate_sel    (rate_sel),
    .gain_req    (gain_req),
    .SPI_SCK     (SPI_SCK),
    .AMP_CS      (AMP_CS),
    .AD_CONV     (AD_CONV),
    .DAC_CS      (DAC_CS),
    .adc_window  (adc_window),
    .dac_sel     (dac_sel),
    .mosi_sel    (mosi_sel),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  always #10 CLK_50M = ~CLK_50M;

  localparam int EvAmpFall = 0;
  localparam int EvAmpRise = 1;
  localparam int EvConv    = 2;
  localparam int EvValid   = 3;
  localparam int EvDacFall = 4;
  localparam int EvDacRise = 5;
  localparam int EvBusyEnd = 6;

  typedef struct {
    int kind;
    int idx;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  nfall = 0;

  function automatic string ev_name(input int k);
    case (k)
      EvAmpFall: return "amp_cs_fall";
      EvAmpRise: return "amp_cs_rise";
      EvConv:    return "ad_conv_rise";
      EvValid:   return "sample_valid";
      EvDacFall: return "dac_cs_fall";
      EvDacRise: return "dac_cs_rise";
      EvBusyEnd: return "busy_fall";
      default:   return "none";
    endcase
  endfunction

  function automatic ev_t mk(input int k, input int i);
    ev_t e;
    e.kind = k;
    e.idx  = i;
    return e;
  endfunction

  // Expected events of one frame whose first SCK period follows fall index base
  task automatic push_frame(input int base, input bit amp);
    int c;
    c = base;
    if (amp) begin
      exp_q.push_back(mk(EvAmpFall, base));
      exp_q.push_back(mk(EvAmpRise, base + 8));
      c = base + 8;
    end
    exp_q.push_back(mk(EvConv, c));
    exp_q.push_back(mk(EvValid, c + 35));
    exp_q.push_back(mk(EvDacFall, c + 35));
    exp_q.push_back(mk(EvDacRise, c + 67));
    exp_q.push_back(mk(EvDacFall, c + 68));
    exp_q.push_back(mk(EvDacRise, c + 100));
  endtask

  // Monitor: counts SCK falls and matches output edges against the scoreboard
  initial begin
    logic p_sck, p_amp, p_conv, p_dac, p_busy;
    logic [6:0] hit;
    ev_t e;
    p_sck = 1'b0; p_amp = 1'b1; p_conv = 1'b0; p_dac = 1'b1; p_busy = 1'b0;
    forever begin
      @(negedge CLK_50M);
      if (!RST_N) begin
        nfall = 0;
      end else begin
        if (p_sck && !SPI_SCK) nfall++;
        hit = '0;
        hit[EvAmpFall] = p_amp && !AMP_CS;
        hit[EvAmpRise] = !p_amp && AMP_CS;
        hit[EvConv]    = !p_conv && AD_CONV;
        hit[EvValid]   = sample_valid;
        hit[EvDacFall] = p_dac && !DAC_CS;
        hit[EvDacRise] = !p_dac && DAC_CS;
        hit[EvBusyEnd] = p_busy && !busy;
        for (int k = 0; k < 7; k++) begin
          if (hit[k]) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL sb_unexpected: got %s at idx=%0d, required no event",
                       ev_name(k), nfall);
            end else begin
              e = exp_q.pop_front();
              if (e.kind !== k || e.idx !== nfall) begin
                bad++;
                $display("FAIL sb_event: got %s at idx=%0d, required %s at idx=%0d",
                         ev_name(k), nfall, ev_name(e.kind), e.idx);
              end
            end
          end
        end
      end
      p_sck = SPI_SCK; p_amp = AMP_CS; p_conv = AD_CONV; p_dac = DAC_CS; p_busy = busy;
    end
  end

  task automatic wait_qsize(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK_50M); #1;
      if (exp_q.size() <= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_falls(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK_50M); #1;
      if (nfall >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Clocks between two consecutive SCK rising edges; -1 if the budget runs out
  task automatic measure_period(input int budget, output int per);
    logic prev;
    int   n, first;
    prev = SPI_SCK; first = -1; per = -1; n = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK_50M); #1;
      n++;
      if (!prev && SPI_SCK) begin
        if (first < 0) begin
          first = n;
        end else begin
          per = n - first;
          break;
        end
      end
      prev = SPI_SCK;
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    RST_N = 1'b0; enable = 1'b1; rate_sel = 1'b0; gain_req = 1'b0;
    repeat (3) @(posedge CLK_50M);
    #1;
    obs = {SPI_SCK, AMP_CS, AD_CONV, DAC_CS, adc_window, dac_sel, mosi_sel, sample_valid, busy};
    total++;
    if (obs !== 10'b0101000000) begin
      bad++;
      $display("FAIL reset_outputs: got %b, required %b", obs, 10'b0101000000);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
    exp_q.delete();
    RST_N = 1'b1;
  endtask

  task automatic test_first_frame();
    int per;
    bit ok;
    push_frame(1, 1'b1);
    measure_period(200, per);
    total++;
    if (per !== 8) begin
      bad++;
      $display("FAIL first_sck_period: got %0d, required 8", per);
    end
    total++;
    if (AMP_CS !== 1'b0 || mosi_sel !== 2'd1) begin
      bad++;
      $display("FAIL amp_decode: got cs=%b sel=%0d, required cs=0 sel=1", AMP_CS, mosi_sel);
    end
    wait_qsize(5, 2000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL first_conv_wait: got timeout, required ad_conv");
    end
    wait_falls(nfall + 1, 200, ok);
    @(posedge CLK_50M); #1;
    total++;
    if (!ok || adc_window !== 1'b1 || AD_CONV !== 1'b0) begin
      bad++;
      $display("FAIL read_start: got win=%b conv=%b, required win=1 conv=0", adc_window, AD_CONV);
    end
    wait_qsize(0, 3000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL first_frame_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_second_frame();
    bit ok;
    push_frame(129, 1'b0);
    wait_qsize(5, 3000, ok);
    total++;
    if (!ok || AD_CONV !== 1'b1 || AMP_CS !== 1'b1) begin
      bad++;
      $display("FAIL second_conv: got ok=%b conv=%b amp=%b, required 1 1 1", ok, AD_CONV, AMP_CS);
    end
  endtask

  task automatic test_rate_change();
    int per;
    bit ok;
    wait_qsize(3, 2000, ok);
    rate_sel = 1'b1;
    measure_period(200, per);
    total++;
    if (!ok || per !== 8) begin
      bad++;
      $display("FAIL mid_frame_period: got %0d, required 8", per);
    end
    push_frame(257, 1'b0);
    wait_qsize(5, 5000, ok);
    measure_period(200, per);
    total++;
    if (!ok || per !== 20) begin
      bad++;
      $display("FAIL slow_period: got %0d, required 20", per);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int n0;
    wait_falls(257 + 50, 4000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL reach_pos50: got nfall=%0d, required 307", nfall);
    end
    enable = 1'b0;
    exp_q.push_back(mk(EvBusyEnd, 385));
    wait_qsize(2, 4000, ok);
    total++;
    if (!ok || dac_sel !== 1'b1 || mosi_sel !== 2'd2 || DAC_CS !== 1'b0) begin
      bad++;
      $display("FAIL dac_b_decode: got sel=%b mosi=%0d cs=%b, required 1 2 0",
               dac_sel, mosi_sel, DAC_CS);
    end
    wait_qsize(0, 4000, ok);
    total++;
    if (!ok || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_end: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
    n0 = nfall;
    wait_falls(n0 + 30, 2000, ok);
    total++;
    if (!ok || AD_CONV !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL parked: got falls=%0d conv=%b busy=%b, required %0d 0 0",
               nfall - n0, AD_CONV, busy, 30);
    end
  endtask

  task automatic test_gain_during_amp();
    bit ok;
    RST_N = 1'b0; rate_sel = 1'b0; enable = 1'b1;
    repeat (3) @(posedge CLK_50M);
    #1;
    exp_q.delete();
    RST_N = 1'b1;
    push_frame(1, 1'b1);
    push_frame(129, 1'b1);
    push_frame(257, 1'b0);
    wait_qsize(21, 500, ok);
    total++;
    if (!ok || AMP_CS !== 1'b0) begin
      bad++;
      $display("FAIL gain_amp_start: got amp=%b, required 0", AMP_CS);
    end
    gain_req = 1'b1;
    @(posedge CLK_50M); #1;
    gain_req = 1'b0;
    wait_qsize(5, 5000, ok);
    total++;
    if (!ok || AMP_CS !== 1'b1) begin
      bad++;
      $display("FAIL third_frame_conv: got ok=%b amp=%b, required 1 1", ok, AMP_CS);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    wait_qsize(3, 2000, ok);
    repeat (10) @(posedge CLK_50M);
    #1;
    total++;
    if (!ok || DAC_CS !== 1'b0 || mosi_sel !== 2'd2 || dac_sel !== 1'b0) begin
      bad++;
      $display("FAIL dac_a_decode: got cs=%b mosi=%0d sel=%b, required 0 2 0",
               DAC_CS, mosi_sel, dac_sel);
    end
    RST_N = 1'b0;
    @(posedge CLK_50M); #1;
    total++;
    if (DAC_CS !== 1'b1 || mosi_sel !== 2'd0 || busy !== 1'b0 || SPI_SCK !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got cs=%b mosi=%0d busy=%b sck=%b, required 1 0 0 0",
               DAC_CS, mosi_sel, busy, SPI_SCK);
    end
    exp_q.delete();
    repeat (2) @(posedge CLK_50M);
    #1;
    RST_N = 1'b1;
    push_frame(1, 1'b1);
    wait_qsize(0, 3000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL restart_amp: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_second_frame();
    test_rate_change();
    test_enable_drop();
    test_gain_during_amp();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
